uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Byte-stream command decoder between the UART receiver and transmitter of the board top level.
- Consumes received bytes (data + write strobe), parses fixed 5-byte frames, and reads/writes a small register bank that drives PWM compare/enable values.
- Queues ACK/NAK/readback bytes for the UART transmitter through a data/empty/read handshake.

Parameters:
- NUM_REGS, 8, number of 8-bit registers; address range 0..NUM_REGS-1
- TIMEOUT_CYCLES, 5000000, inter-byte idle cycles (100 ms at 50 MHz) before an incomplete frame is discarded
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- rx_write  in  1  one-cycle strobe: rx_data valid
- rx_data  in  8  received byte
- tx_data  out  8  byte at head of response queue
- tx_empty  out  1  1 = no byte for transmitter
- tx_read  in  1  one-cycle pulse: transmitter has taken tx_data
- regs_o  out  8*NUM_REGS  register bank, reg i at bits [8i+7:8i]
- reg_update  out  1  one-cycle pulse when any register is written
- frame_err  out  1  sticky: checksum/cmd/addr error seen; cleared only by reset
- resp_overflow  out  1  sticky: response dropped because queue was not empty

Behaviour:
- Frame format: SYNC, CMD, ADDR, DATA, CHK, where CHK = CMD ^ ADDR ^ DATA. CMD 8'h57 ('W') = write; CMD 8'h52 ('R') = read, in which DATA is ignored but still checked.
- Reset values: all regs 0, tx_empty=1, tx_data=0, reg_update=0, both sticky flags 0, FSM in IDLE, queue empty, timeout counter 0.
- FSM states: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC. Each advances only on rx_write.
  - IDLE: any byte other than SYNC is ignored.
  - SYNC inside a frame is ordinary data.
  - GET_CHK -> EXEC on the checksum byte.
  - EXEC lasts exactly 1 cycle, then returns to IDLE.
- EXEC, good frame (checksum ok, CMD valid, ADDR < NUM_REGS):
  - Write: reg[ADDR] <= DATA; reg_update=1 in the following cycle; response 8'h06.
  - Read: response 8'h06 followed by reg[ADDR] (2 bytes).
- EXEC, bad frame (any error): no register change; response 8'h15; frame_err <= 1.
- Response queue: 2-entry FIFO.
  - A response is enqueued in EXEC only if the queue is empty at EXEC. Otherwise the whole response is dropped and resp_overflow <= 1. The register write is still applied.
  - tx_data/tx_empty are registered and show the head entry. They update in the cycle after an enqueue or a tx_read.
  - tx_read while tx_empty=1 is ignored.
  - tx_read in the EXEC cycle acts on the old queue contents before the new response is enqueued.
- Timeout:
  - Counter clears on every rx_write and is held at 0 in IDLE.
  - In any other non-EXEC state it increments each cycle. On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE, the partial frame is discarded, and no response or flag is produced.
- rx_write during EXEC is captured as the first byte seen in IDLE; no byte is lost.
- Reset mid-frame or mid-response clears everything immediately; queued bytes are lost.
- Widths: address compare is unsigned 8-bit. Addresses >= NUM_REGS always NAK, including 8'hFF.

Decomposition:
- Shared package uart_pkg gets:
  - constants CMD_WRITE=8'h57, CMD_READ=8'h52, RESP_ACK=8'h06, RESP_NAK=8'h15, SYNC default
  - typedef enum for the parser states (parse_state_t)
- One sub-module, resp_fifo: 2-deep, 8-bit, registered head output, push/pop/empty/full ports. Reusable later as the UART transmit buffer.

Test Plan:
- Write: A5 57 03 7F 2B -> regs_o[31:24]=8'h7F, one reg_update pulse, tx stream 06, then tx_empty=1.
- Read back: after the write, A5 52 03 00 51 -> tx stream 06 7F; regs unchanged; no reg_update.
- Bad checksum: A5 57 01 10 00 -> reg1 stays 0, tx 15, frame_err=1, and frame_err stays 1 after a following good frame.
- Bad address: A5 57 08 01 5E (NUM_REGS=8) -> NAK 15, no register change. Bad CMD: A5 41 00 00 41 -> NAK 15.
- Timeout (TIMEOUT_CYCLES=100 in bench): A5 57 02, idle 150 cycles, then A5 57 02 55 00 -> first fragment discarded; reg2=8'h55, single ACK 06, frame_err=0.
- Overflow and reset: hold tx_read=0; send read frame to reg 3 (2 bytes queued), then a write A5 57 00 AA FD -> reg0=8'hAA, resp_overflow=1, queue still 06 7F. Assert reset mid-frame -> all regs 0, tx_empty=1, flags 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART command parser.
// Holds the command/response byte codes, the default frame-start marker,
// and the parser state encoding.
package uart_pkg;

  localparam logic [7:0] CMD_WRITE    = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ     = 8'h52;  // 'R'
  localparam logic [7:0] RESP_ACK     = 8'h06;
  localparam logic [7:0] RESP_NAK     = 8'h15;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_ADDR,
    GET_DATA,
    GET_CHK,
    EXEC
  } parse_state_t;

endpackage

// File: rtl/resp_fifo.sv
// Two-entry byte queue with a registered head; a push may carry one or two bytes.
// Ports: push_i/push_two_i/push_dat_i/push_dat2_i enqueue, pop_i dequeues the head,
//        head_o/empty_o/full_o are registers that update the cycle after push/pop.
// Pop is applied before push, pop on empty is ignored, and a push that does not fit is dropped whole.
module resp_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       push_two_i,
  input  logic [7:0] push_dat_i,
  input  logic [7:0] push_dat2_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       full_o
);

  logic [7:0] e0_q, e0_d;
  logic [7:0] e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (pop_i && cnt_q != 2'd0) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end
    if (push_i) begin
      if (cnt_d == 2'd0) begin
        e0_d = push_dat_i;
        if (push_two_i) begin
          e1_d  = push_dat2_i;
          cnt_d = 2'd2;
        end else begin
          cnt_d = 2'd1;
        end
      end else if (cnt_d == 2'd1 && !push_two_i) begin
        e1_d  = push_dat_i;
        cnt_d = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = e0_q;
  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SYNC/CMD/ADDR/DATA/CHK frames from the UART receiver into a register bank.
// Ports: rx_write/rx_data in, tx_data/tx_empty/tx_read response queue, regs_o bank,
//        reg_update pulse, frame_err and resp_overflow sticky flags.
// Responses go out through resp_fifo; a response finding the queue busy is dropped.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_write,
  input  logic [7:0]            rx_data,
  output logic [7:0]            tx_data,
  output logic                  tx_empty,
  input  logic                  tx_read,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic                  reg_update,
  output logic                  frame_err,
  output logic                  resp_overflow
);

  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  parse_state_t          state_q;
  logic [7:0]            cmd_q, addr_q, data_q, chk_q;
  logic [TW-1:0]         tmo_q;
  logic [8*NUM_REGS-1:0] regs_q;
  logic                  reg_update_q, frame_err_q, resp_overflow_q;

  logic       frame_good, is_read, resp_room, fifo_full;
  logic [7:0] rd_dat;

  // Address compare done on 9 bits so 8'hFF never aliases into range.
  assign frame_good = ((cmd_q ^ addr_q ^ data_q) == chk_q)
                   && (cmd_q == CMD_WRITE || cmd_q == CMD_READ)
                   && ({1'b0, addr_q} < 9'(NUM_REGS));
  assign is_read    = (cmd_q == CMD_READ);
  // The whole response is queued only into an empty queue, judged before any same-cycle pop.
  assign resp_room  = tx_empty & ~fifo_full;

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == 8'(i)) rd_dat = regs_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cmd_q           <= '0;
      addr_q          <= '0;
      data_q          <= '0;
      chk_q           <= '0;
      tmo_q           <= '0;
      regs_q          <= '0;
      reg_update_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      resp_overflow_q <= 1'b0;
    end else begin
      reg_update_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (rx_write && rx_data == SYNC_BYTE) state_q <= GET_CMD;
        end
        GET_CMD, GET_ADDR, GET_DATA, GET_CHK: begin
          if (rx_write) begin
            tmo_q <= '0;
            case (state_q)
              GET_CMD:  begin cmd_q  <= rx_data; state_q <= GET_ADDR; end
              GET_ADDR: begin addr_q <= rx_data; state_q <= GET_DATA; end
              GET_DATA: begin data_q <= rx_data; state_q <= GET_CHK;  end
              default:  begin chk_q  <= rx_data; state_q <= EXEC;     end
            endcase
          end else if (tmo_q == TMO_LAST) begin
            // Stale partial frame: drop silently.
            tmo_q   <= '0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        EXEC: begin
          tmo_q <= '0;
          if (frame_good && !is_read) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (addr_q == 8'(i)) regs_q[8*i +: 8] <= data_q;
            end
            reg_update_q <= 1'b1;
          end
          if (!frame_good) frame_err_q <= 1'b1;
          if (!resp_room) resp_overflow_q <= 1'b1;
          // A byte arriving now is treated as the first byte seen in IDLE.
          state_q <= (rx_write && rx_data == SYNC_BYTE) ? GET_CMD : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  resp_fifo u_resp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     ((state_q == EXEC) && resp_room),
    .push_two_i (frame_good && is_read),
    .push_dat_i (frame_good ? RESP_ACK : RESP_NAK),
    .push_dat2_i(rd_dat),
    .pop_i      (tx_read),
    .head_o     (tx_data),
    .empty_o    (tx_empty),
    .full_o     (fifo_full)
  );

  assign regs_o        = regs_q;
  assign reg_update    = reg_update_q;
  assign frame_err     = frame_err_q;
  assign resp_overflow = resp_overflow_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames plus randomized frames
// compared against a frame-level reference model (register array, response byte queue).
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_uart_cmd_parser;

  localparam int NR  = 8;
  localparam int TMO = 100;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            rx_write = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            tx_read = 1'b0;
  logic [7:0]      tx_data;
  logic            tx_empty;
  logic [8*NR-1:0] regs_o;
  logic            reg_update, frame_err, resp_overflow;

  always #5 clk = ~clk;

  uart_cmd_parser #(.NUM_REGS(NR), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_write(rx_write), .rx_data(rx_data),
    .tx_data(tx_data), .tx_empty(tx_empty), .tx_read(tx_read),
    .regs_o(regs_o), .reg_update(reg_update), .frame_err(frame_err),
    .resp_overflow(resp_overflow)
  );

  int n_checks = 0;
  int n_err = 0;
  int upd_cnt = 0;
  int upd_base = 0;

  // Reference model state
  logic [7:0] m_regs [NR];
  logic [7:0] m_txq [$];
  logic       m_ferr, m_ovf;
  int         m_exp_upd;

  always @(negedge clk) if (reg_update) upd_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_write = 1'b1;
    rx_data  = b;
    tick();
    rx_write = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_txq.delete();
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    m_exp_upd = 0;
  endtask

  function automatic logic [63:0] m_pack();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[8*i +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic model_exec(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] k);
    logic good;
    good = ((c ^ a ^ d) == k) && (c == 8'h57 || c == 8'h52) && (int'(a) < NR);
    m_exp_upd = 0;
    if (good && c == 8'h57) begin
      m_regs[a[2:0]] = d;
      m_exp_upd = 1;
    end
    if (!good) m_ferr = 1'b1;
    if (m_txq.size() == 0) begin
      if (good) begin
        m_txq.push_back(8'h06);
        if (c == 8'h52) m_txq.push_back(m_regs[a[2:0]]);
      end else begin
        m_txq.push_back(8'h15);
      end
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] k, input int gap);
    logic [7:0] fr [5];
    fr = '{8'hA5, c, a, d, k};
    upd_base = upd_cnt;
    for (int i = 0; i < 5; i++) begin
      send_byte(fr[i]);
      if (i < 4) repeat (gap) tick();
    end
    model_exec(c, a, d, k);
  endtask

  task automatic drain(input string tag);
    int w;
    while (m_txq.size() > 0) begin
      w = 0;
      while (tx_empty && w < 20) begin
        tick();
        w++;
      end
      check_eq({tag, "_avail"}, 64'(tx_empty), 64'(0));
      if (tx_empty) begin
        m_txq.delete();
        break;
      end
      check_eq({tag, "_tx"}, 64'(tx_data), 64'(m_txq.pop_front()));
      tx_read = 1'b1;
      tick();
      tx_read = 1'b0;
    end
    tick();
    tick();
    check_eq({tag, "_empty"}, 64'(tx_empty), 64'(1));
    // Resynchronise if the design queued extra bytes.
    for (int i = 0; i < 4 && !tx_empty; i++) begin
      tx_read = 1'b1;
      tick();
      tx_read = 1'b0;
      tick();
    end
  endtask

  task automatic check_frame(input string tag);
    repeat (3) tick();
    check_eq({tag, "_regs"}, regs_o, m_pack());
    check_eq({tag, "_upd"}, 64'(upd_cnt - upd_base), 64'(m_exp_upd));
    check_eq({tag, "_ferr"}, 64'(frame_err), 64'(m_ferr));
    check_eq({tag, "_ovf"}, 64'(resp_overflow), 64'(m_ovf));
    drain(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] c, a, d, k, j;
    int r;

    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_eq("rst_regs", regs_o, 64'(0));
    check_eq("rst_empty", 64'(tx_empty), 64'(1));
    check_eq("rst_txdata", 64'(tx_data), 64'(0));
    check_eq("rst_upd", 64'(reg_update), 64'(0));
    check_eq("rst_ferr", 64'(frame_err), 64'(0));
    check_eq("rst_ovf", 64'(resp_overflow), 64'(0));

    // Write then read back register 3
    send_frame(8'h57, 8'h03, 8'h7F, 8'h2B, 0);
    check_frame("wr3");
    check_eq("wr3_byte", 64'(regs_o[31:24]), 64'h7F);
    send_frame(8'h52, 8'h03, 8'h00, 8'h51, 1);
    check_frame("rd3");

    // Partial frame abandoned by the inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h57);
    send_byte(8'h02);
    repeat (150) tick();
    send_frame(8'h57, 8'h02, 8'h55, 8'h00, 0);
    check_frame("tmo");
    check_eq("tmo_reg2", 64'(regs_o[23:16]), 64'h55);

    // Error frames: checksum, address, command
    send_frame(8'h57, 8'h01, 8'h10, 8'h00, 0);
    check_frame("badchk");
    send_frame(8'h57, 8'h08, 8'h01, 8'h5E, 0);
    check_frame("badaddr");
    send_frame(8'h41, 8'h00, 8'h00, 8'h41, 0);
    check_frame("badcmd");
    send_frame(8'h57, 8'h04, 8'h44, 8'h17, 0);
    check_frame("sticky");

    // Randomized frames, junk, fragments, spurious reads
    for (int it = 0; it < 50; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h5A;
        send_byte(j);
        tick();
      end
      if (it % 7 == 3) begin
        send_byte(8'hA5);
        r = $urandom_range(0, 3);
        for (int b = 0; b < r; b++) send_byte(8'($urandom));
        repeat (TMO + 10) tick();
        check_eq("frag_empty", 64'(tx_empty), 64'(1));
      end
      if (it % 5 == 1) begin
        tx_read = 1'b1;
        tick();
        tx_read = 1'b0;
        tick();
        check_eq("spur_read", 64'(tx_empty), 64'(1));
      end
      r = $urandom_range(0, 9);
      c = (r < 4) ? 8'h57 : (r < 8) ? 8'h52 : 8'($urandom);
      a = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 9));
      d = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
      k = c ^ a ^ d;
      if ($urandom_range(0, 4) == 0) k = k ^ 8'(32'd1 << $urandom_range(0, 7));
      send_frame(c, a, d, k, $urandom_range(0, 2));
      check_frame("rand");
    end

    // Overflow: read queues two bytes, back-to-back write finds the queue busy
    send_frame(8'h52, 8'h03, 8'h00, 8'h51, 0);
    send_frame(8'h57, 8'h00, 8'hAA, 8'hFD, 0);
    repeat (3) tick();
    check_eq("ovf_flag", 64'(resp_overflow), 64'(1));
    check_eq("ovf_reg0", 64'(regs_o[7:0]), 64'hAA);
    check_eq("ovf_head", 64'(tx_data), 64'h06);
    check_frame("ovf");

    // Reset in the middle of a frame with a response still queued
    send_frame(8'h52, 8'h00, 8'h00, 8'h52, 0);
    repeat (3) tick();
    send_byte(8'hA5);
    send_byte(8'h57);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_regs", regs_o, 64'(0));
    check_eq("mid_rst_empty", 64'(tx_empty), 64'(1));
    check_eq("mid_rst_ferr", 64'(frame_err), 64'(0));
    check_eq("mid_rst_ovf", 64'(resp_overflow), 64'(0));
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    send_frame(8'h57, 8'h07, 8'h3C, 8'h6C, 1);
    check_frame("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
